// File: rtl/seq_match_ctrl.sv
// Run controller for serial pattern detection with bit-budget / match-limit termination.
// Optional build macro SEQ_CTRL_NONOVERLAP_EN selects non-overlapping match detection.
module seq_match_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int BIT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic [BIT_W-1:0] cfg_max_bits,
  input  logic [CNT_W-1:0] cfg_match_limit,
  input  logic             start,
  input  logic             abort,
  input  logic             x,
  input  logic             x_valid,
  output logic             busy,
  output logic             match,
  output logic             done,
  output logic [1:0]       end_cause,
  output logic [CNT_W-1:0] match_count,
  output logic [BIT_W-1:0] bits_seen
);

  localparam int RL_W = 5;
  localparam logic [RL_W-1:0] RL_MAX = RL_W'(PAT_W);

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_BUDGET = 2'b01;
  localparam logic [1:0] CAUSE_LIMIT  = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_n;

  logic [PAT_W-1:0] pat_q;
  logic [RL_W-1:0]  len_q;
  logic [BIT_W-1:0] max_bits_q;
  logic [CNT_W-1:0] limit_q;

  logic [PAT_W-1:0] hist_q;
  logic [RL_W-1:0]  rl_q;

  logic [PAT_W-1:0] hist_upd;
  logic [RL_W-1:0]  rl_inc;
  logic [RL_W-1:0]  rl_nxt;
  logic [CNT_W-1:0] mc_upd;
  logic [BIT_W-1:0] bs_upd;
  logic             accept;
  logic             hit;
  logic             lim_hit;
  logic             bud_hit;

  // Length 0 behaves as 1; anything beyond the history width is capped.
  function automatic logic [RL_W-1:0] clamp_len(input logic [3:0] l);
    if (l == 4'd0)
      return RL_W'(1);
    else if (int'(l) > PAT_W)
      return RL_MAX;
    else
      return RL_W'(l);
  endfunction

  function automatic logic [PAT_W-1:0] len_mask(input logic [RL_W-1:0] l);
    logic [PAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < PAT_W; i++)
      if (i < int'(l)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    if (&v)
      return v;
    else
      return v + 1'b1;
  endfunction

  function automatic logic [BIT_W-1:0] sat_inc_bits(input logic [BIT_W-1:0] v);
    if (&v)
      return v;
    else
      return v + 1'b1;
  endfunction

  // Next-state and per-bit evaluation
  always_comb begin
    hist_upd = {hist_q[PAT_W-2:0], x};
    rl_inc   = (rl_q == RL_MAX) ? rl_q : rl_q + 1'b1;
    hit      = (((hist_upd ^ pat_q) & len_mask(len_q)) == '0) && (rl_inc >= len_q);
    mc_upd   = hit ? sat_inc_cnt(match_count) : match_count;
    bs_upd   = sat_inc_bits(bits_seen);
    accept   = (state == RUN) && x_valid && !abort;
    lim_hit  = (limit_q != '0) && (mc_upd == limit_q);
    bud_hit  = (max_bits_q != '0) && (bs_upd == max_bits_q);
`ifdef SEQ_CTRL_NONOVERLAP_EN
    rl_nxt   = hit ? '0 : rl_inc;
`else
    rl_nxt   = rl_inc;
`endif
    state_n  = state;
    case (state)
      IDLE:    if (start && !abort) state_n = RUN;
      RUN: begin
        if (abort)
          state_n = IDLE;
        else if (accept && (lim_hit || bud_hit))
          state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Shadow configuration, run datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q       <= '0;
      len_q       <= RL_W'(1);
      max_bits_q  <= '0;
      limit_q     <= '0;
      hist_q      <= '0;
      rl_q        <= '0;
      busy        <= 1'b0;
      match       <= 1'b0;
      done        <= 1'b0;
      end_cause   <= CAUSE_NONE;
      match_count <= '0;
      bits_seen   <= '0;
    end else begin
      match <= 1'b0;
      busy  <= (state_n == RUN);
      done  <= (state_n == DONE);
      if (cfg_we && (state != RUN)) begin
        pat_q      <= cfg_pattern;
        len_q      <= clamp_len(cfg_len);
        max_bits_q <= cfg_max_bits;
        limit_q    <= cfg_match_limit;
      end
      case (state)
        IDLE: begin
          if (start && !abort) begin
            hist_q      <= '0;
            rl_q        <= '0;
            match_count <= '0;
            bits_seen   <= '0;
            end_cause   <= CAUSE_NONE;
          end
        end
        RUN: begin
          if (abort) begin
            end_cause <= CAUSE_NONE;
          end else if (accept) begin
            hist_q      <= hist_upd;
            rl_q        <= rl_nxt;
            match_count <= mc_upd;
            bits_seen   <= bs_upd;
            match       <= hit;
            if (lim_hit)
              end_cause <= CAUSE_LIMIT;
            else if (bud_hit)
              end_cause <= CAUSE_BUDGET;
          end
        end
        DONE: begin
          if (abort) end_cause <= CAUSE_NONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Table-driven, scoreboarded bench for seq_match_ctrl (default parameters).
module tb_seq_match_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic [15:0] cfg_max_bits;
  logic [7:0]  cfg_match_limit;
  logic        start, abort, x, x_valid;
  logic        busy, match, done;
  logic [1:0]  end_cause;
  logic [7:0]  match_count;
  logic [15:0] bits_seen;

  seq_match_ctrl dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_max_bits(cfg_max_bits), .cfg_match_limit(cfg_match_limit),
    .start(start), .abort(abort), .x(x), .x_valid(x_valid),
    .busy(busy), .match(match), .done(done), .end_cause(end_cause),
    .match_count(match_count), .bits_seen(bits_seen)
  );

  always #5 clk = ~clk;

`ifdef SEQ_CTRL_NONOVERLAP_EN
  localparam bit NONOV = 1'b1;
`else
  localparam bit NONOV = 1'b0;
`endif

  localparam logic lo = 1'b0;
  localparam logic hi = 1'b1;
  // Expectations that differ between overlapping and non-overlapping detection
  localparam logic       M_OV   = NONOV ? 1'b0 : 1'b1;
  localparam logic [7:0] MC_T1  = NONOV ? 8'd1 : 8'd2;
  localparam logic [7:0] MC_T24 = NONOV ? 8'd1 : 8'd2;
  localparam logic [7:0] MC_T25 = NONOV ? 8'd1 : 8'd3;

  typedef struct packed {
    logic        busy, match, done;
    logic [1:0]  cause;
    logic [7:0]  mc;
    logic [15:0] bs;
  } exp_t;

  typedef struct packed {
    logic        rst, we;
    logic [7:0]  pat;
    logic [3:0]  len;
    logic [15:0] mb;
    logic [7:0]  ml;
    logic        st, ab, xv, xx;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic exp_t E(input logic b, input logic m, input logic d, input logic [1:0] c,
                             input logic [7:0] mc, input logic [15:0] bs);
    exp_t e;
    e.busy = b; e.match = m; e.done = d; e.cause = c; e.mc = mc; e.bs = bs;
    return e;
  endfunction

  function automatic vec_t C(input logic [7:0] p, input logic [3:0] l, input logic [15:0] mb,
                             input logic [7:0] ml, input logic st, input exp_t e);
    vec_t v;
    v = '0;
    v.we = 1'b1; v.pat = p; v.len = l; v.mb = mb; v.ml = ml; v.st = st; v.e = e;
    return v;
  endfunction

  function automatic vec_t D(input logic st, input logic ab, input logic xv, input logic xx,
                             input exp_t e);
    vec_t v;
    v = '0;
    v.st = st; v.ab = ab; v.xv = xv; v.xx = xx; v.e = e;
    return v;
  endfunction

  // One accepted bit with no control activity
  function automatic vec_t B(input logic xx, input exp_t e);
    return D(lo, lo, hi, xx, e);
  endfunction

  task automatic check(input string nm);
    exp_t w;
    w = sb.pop_front();
    n_chk++;
    if ({busy, match, done, end_cause, match_count, bits_seen} === w)
      n_pass++;
    else
      $display("FAIL %s: got busy=%b match=%b done=%b cause=%b mc=%0d bs=%0d, want busy=%b match=%b done=%b cause=%b mc=%0d bs=%0d",
               nm, busy, match, done, end_cause, match_count, bits_seen,
               w.busy, w.match, w.done, w.cause, w.mc, w.bs);
  endtask

  task automatic step(input vec_t v, input string nm);
    reset = v.rst; cfg_we = v.we; cfg_pattern = v.pat; cfg_len = v.len;
    cfg_max_bits = v.mb; cfg_match_limit = v.ml;
    start = v.st; abort = v.ab; x_valid = v.xv; x = v.xx;
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    check(nm);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_max_bits = '0;
    cfg_match_limit = '0; start = 1'b0; abort = 1'b0; x = 1'b0; x_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    tbl.push_back(D(lo, lo, lo, lo, E(lo, lo, lo, 2'd0, 8'd0, 16'd0)));
    // Overlapping detection of 1011, cfg and start in the same cycle
    tbl.push_back(C(8'h0B, 4'd4, 16'd0, 8'd0, hi, E(hi, lo, lo, 2'd0, 8'd0, 16'd0)));
    tbl.push_back(B(hi, E(hi, lo, lo, 2'd0, 8'd0, 16'd1)));
    tbl.push_back(B(lo, E(hi, lo, lo, 2'd0, 8'd0, 16'd2)));
    tbl.push_back(B(hi, E(hi, lo, lo, 2'd0, 8'd0, 16'd3)));
    tbl.push_back(B(hi, E(hi, hi, lo, 2'd0, 8'd1, 16'd4)));
    tbl.push_back(B(lo, E(hi, lo, lo, 2'd0, 8'd1, 16'd5)));
    tbl.push_back(B(hi, E(hi, lo, lo, 2'd0, 8'd1, 16'd6)));
    tbl.push_back(B(hi, E(hi, M_OV, lo, 2'd0, MC_T1, 16'd7)));
    tbl.push_back(D(lo, hi, lo, lo, E(lo, lo, lo, 2'd0, MC_T1, 16'd7)));
    // Bit budget of 5 with gaps in x_valid, then start during DONE
    tbl.push_back(C(8'h07, 4'd3, 16'd5, 8'd0, lo, E(lo, lo, lo, 2'd0, MC_T1, 16'd7)));
    tbl.push_back(D(hi, lo, lo, lo, E(hi, lo, lo, 2'd0, 8'd0, 16'd0)));
    tbl.push_back(B(hi, E(hi, lo, lo, 2'd0, 8'd0, 16'd1)));
    tbl.push_back(D(lo, lo, lo, hi, E(hi, lo, lo, 2'd0, 8'd0, 16'd1)));
    tbl.push_back(B(hi, E(hi, lo, lo, 2'd0, 8'd0, 16'd2)));
    tbl.push_back(B(hi, E(hi, hi, lo, 2'd0, 8'd1, 16'd3)));
    tbl.push_back(D(lo, lo, lo, hi, E(hi, lo, lo, 2'd0, 8'd1, 16'd3)));
    tbl.push_back(B(hi, E(hi, M_OV, lo, 2'd0, MC_T24, 16'd4)));
    tbl.push_back(B(hi, E(lo, M_OV, hi, 2'd1, MC_T25, 16'd5)));
    tbl.push_back(D(hi, lo, lo, lo, E(lo, lo, lo, 2'd1, MC_T25, 16'd5)));
    // Match limit of 2 on pattern 01; trailing bits ignored
    tbl.push_back(C(8'h01, 4'd2, 16'd100, 8'd2, lo, E(lo, lo, lo, 2'd1, MC_T25, 16'd5)));
    tbl.push_back(D(hi, lo, lo, lo, E(hi, lo, lo, 2'd0, 8'd0, 16'd0)));
    tbl.push_back(B(lo, E(hi, lo, lo, 2'd0, 8'd0, 16'd1)));
    tbl.push_back(B(hi, E(hi, hi, lo, 2'd0, 8'd1, 16'd2)));
    tbl.push_back(B(lo, E(hi, lo, lo, 2'd0, 8'd1, 16'd3)));
    tbl.push_back(B(hi, E(lo, hi, hi, 2'd2, 8'd2, 16'd4)));
    tbl.push_back(B(lo, E(lo, lo, lo, 2'd2, 8'd2, 16'd4)));
    tbl.push_back(B(hi, E(lo, lo, lo, 2'd2, 8'd2, 16'd4)));
    // Abort outranks a same-cycle bit; start+abort in IDLE does nothing
    tbl.push_back(D(hi, lo, lo, lo, E(hi, lo, lo, 2'd0, 8'd0, 16'd0)));
    tbl.push_back(B(lo, E(hi, lo, lo, 2'd0, 8'd0, 16'd1)));
    tbl.push_back(B(hi, E(hi, hi, lo, 2'd0, 8'd1, 16'd2)));
    tbl.push_back(D(lo, hi, hi, lo, E(lo, lo, lo, 2'd0, 8'd1, 16'd2)));
    tbl.push_back(D(hi, hi, lo, lo, E(lo, lo, lo, 2'd0, 8'd1, 16'd2)));
    // len=0 acts as 1
    tbl.push_back(C(8'h01, 4'd0, 16'd0, 8'd0, hi, E(hi, lo, lo, 2'd0, 8'd0, 16'd0)));
    tbl.push_back(B(hi, E(hi, hi, lo, 2'd0, 8'd1, 16'd1)));
    tbl.push_back(B(lo, E(hi, lo, lo, 2'd0, 8'd1, 16'd2)));
    tbl.push_back(B(hi, E(hi, hi, lo, 2'd0, 8'd2, 16'd3)));
    tbl.push_back(B(hi, E(hi, hi, lo, 2'd0, 8'd3, 16'd4)));
    tbl.push_back(D(lo, hi, lo, lo, E(lo, lo, lo, 2'd0, 8'd3, 16'd4)));
    // len=15 clamps to 8
    tbl.push_back(C(8'hFF, 4'd15, 16'd0, 8'd0, hi, E(hi, lo, lo, 2'd0, 8'd0, 16'd0)));
    for (int k = 1; k <= 7; k++)
      tbl.push_back(B(hi, E(hi, lo, lo, 2'd0, 8'd0, 16'(k))));
    tbl.push_back(B(hi, E(hi, hi, lo, 2'd0, 8'd1, 16'd8)));
    tbl.push_back(D(lo, hi, lo, lo, E(lo, lo, lo, 2'd0, 8'd1, 16'd8)));
    // Cleared history must not match until len fresh bits
    tbl.push_back(C(8'h00, 4'd4, 16'd0, 8'd0, hi, E(hi, lo, lo, 2'd0, 8'd0, 16'd0)));
    for (int k = 1; k <= 3; k++)
      tbl.push_back(B(lo, E(hi, lo, lo, 2'd0, 8'd0, 16'(k))));
    tbl.push_back(B(lo, E(hi, hi, lo, 2'd0, 8'd1, 16'd4)));
    tbl.push_back(D(lo, hi, lo, lo, E(lo, lo, lo, 2'd0, 8'd1, 16'd4)));

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Reset mid-run, then default cfg (pattern 0, len 1, no limits)
    step(C(8'h0B, 4'd4, 16'd9, 8'd3, hi, E(hi, lo, lo, 2'd0, 8'd0, 16'd0)), "rst_start");
    step(B(hi, E(hi, lo, lo, 2'd0, 8'd0, 16'd1)), "rst_bit1");
    step(B(hi, E(hi, lo, lo, 2'd0, 8'd0, 16'd2)), "rst_bit2");
    step(B(hi, E(hi, lo, lo, 2'd0, 8'd0, 16'd3)), "rst_bit3");
    v = B(hi, E(lo, lo, lo, 2'd0, 8'd0, 16'd0));
    v.rst = 1'b1;
    step(v, "rst_apply");
    step(D(hi, lo, lo, lo, E(hi, lo, lo, 2'd0, 8'd0, 16'd0)), "dflt_start");
    step(B(lo, E(hi, hi, lo, 2'd0, 8'd1, 16'd1)), "dflt_bit0");
    step(B(hi, E(hi, lo, lo, 2'd0, 8'd1, 16'd2)), "dflt_bit1");
    // cfg_we and start while busy are ignored; the bit still counts
    v = C(8'h01, 4'd1, 16'd1, 8'd1, hi, E(hi, hi, lo, 2'd0, 8'd2, 16'd3));
    v.xv = 1'b1; v.xx = 1'b0;
    step(v, "busy_cfg_ignored");
    step(B(lo, E(hi, hi, lo, 2'd0, 8'd3, 16'd4)), "busy_after");
    step(D(lo, hi, lo, lo, E(lo, lo, lo, 2'd0, 8'd3, 16'd4)), "busy_abort");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
